// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Row-scanning decoder for a 4x3 telephone-style keypad with debounce.
//   Rows are driven low one at a time; the (synchronized) column lines are
//   sampled once per row dwell. A single-column press is debounced over
//   DEBOUNCE_SCANS samples, then held until the same column reads high for
//   DEBOUNCE_SCANS samples. Only one key is tracked at a time (no rollover).
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   kp_col_in    [2:0] raw column lines, active-low, bit0 = column 1
//   kp_row_drv   [3:0] row drive, active-low one-hot, bit0 = row 1
//   row1..row4   debounced row of the held key, active-high
//   col1..col3   debounced column of the held key, active-high
//   key_code     [3:0] last accepted key: 0-9, 10 = '*', 11 = '#'
//   key_valid    one-cycle pulse when a press is accepted
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] kp_col_in,
    output logic [3:0] kp_row_drv,
    output logic       row1,
    output logic       row2,
    output logic       row3,
    output logic       row4,
    output logic       col1,
    output logic       col2,
    output logic       col3,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = (DEBOUNCE_SCANS < 2) ? 1 : $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [CNT_W-1:0] DS_C     = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C   = CNT_W'(0);
    // With a single required sample the press/release is accepted on the
    // very sample that first sees it, skipping the intermediate state.
    localparam bit DS_ONE = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // True when exactly one of the three active-low columns is low.
    function automatic logic single_low(input logic [2:0] cols);
        single_low = (cols == 3'b110) || (cols == 3'b101) || (cols == 3'b011);
    endfunction

    // Index of the low column; only meaningful when single_low() holds.
    function automatic logic [1:0] low_index(input logic [2:0] cols);
        logic [1:0] idx;
        case (cols)
            3'b110:  idx = 2'd0;
            3'b101:  idx = 2'd1;
            3'b011:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Active-high one-hot column vector for column index c.
    function automatic logic [2:0] col_onehot(input logic [1:0] c);
        logic [2:0] v;
        case (c)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Level of the selected column line (1 = released / pulled up).
    function automatic logic col_is_high(input logic [2:0] cols, input logic [1:0] c);
        logic v;
        case (c)
            2'd0:    v = cols[0];
            2'd1:    v = cols[1];
            2'd2:    v = cols[2];
            default: v = 1'b1;
        endcase
        return v;
    endfunction

    // Active-high one-hot row vector for row index r.
    function automatic logic [3:0] row_onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

    // Key legend lookup: rows 1-3 hold digits 1-9, row 4 holds '*', 0, '#'.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case (r)
            2'd3: begin
                case (c)
                    2'd0:    code = 4'd10;
                    2'd1:    code = 4'd0;
                    2'd2:    code = 4'd11;
                    default: code = 4'd0;
                endcase
            end
            default: code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [2:0]       col_meta_r;
    logic [2:0]       col_sync_r;
    logic [DIV_W-1:0] dwell_cnt_r;
    logic             sample_s;

    state_t           state_r;
    state_t           next_state_s;

    logic [1:0]       row_idx_r;
    logic [1:0]       row_idx_nxt_s;
    logic [1:0]       cap_col_r;
    logic [1:0]       cap_col_nxt_s;
    logic [CNT_W-1:0] match_cnt_r;
    logic [CNT_W-1:0] match_cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;

    logic [3:0]       row_drv_r;
    logic [3:0]       row_out_r;
    logic [3:0]       row_out_nxt_s;
    logic [2:0]       col_out_r;
    logic [2:0]       col_out_nxt_s;
    logic [3:0]       key_code_r;
    logic [3:0]       key_code_nxt_s;
    logic             key_valid_r;
    logic             key_valid_nxt_s;

    logic             new_single_s;
    logic [1:0]       new_col_s;
    logic             exact_match_s;
    logic             cap_high_s;

    // Column line decode of the synchronized sample.
    always_comb begin
        new_single_s  = single_low(col_sync_r);
        new_col_s     = low_index(col_sync_r);
        exact_match_s = (col_sync_r == ~col_onehot(cap_col_r));
        cap_high_s    = col_is_high(col_sync_r, cap_col_r);
        cnt_inc_s     = match_cnt_r + ONE_C;
        sample_s      = (dwell_cnt_r == DIV_LAST);
    end

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_meta_r <= 3'b111;
            col_sync_r <= 3'b111;
        end else begin
            col_meta_r <= kp_col_in;
            col_sync_r <= col_meta_r;
        end
    end

    // Row dwell counter; its last count marks the sample cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_cnt_r <= DIV_ZERO;
        end else if (sample_s) begin
            dwell_cnt_r <= DIV_ZERO;
        end else begin
            dwell_cnt_r <= dwell_cnt_r + DIV_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_SCAN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; decisions are only taken on sample cycles.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_SCAN: begin
                if (sample_s && new_single_s) begin
                    next_state_s = DS_ONE ? ST_HELD : ST_DEBOUNCE;
                end else begin
                    next_state_s = ST_SCAN;
                end
            end
            ST_DEBOUNCE: begin
                if (sample_s) begin
                    if (exact_match_s) begin
                        next_state_s = (cnt_inc_s == DS_C) ? ST_HELD : ST_DEBOUNCE;
                    end else begin
                        next_state_s = ST_SCAN;
                    end
                end else begin
                    next_state_s = ST_DEBOUNCE;
                end
            end
            ST_HELD: begin
                if (sample_s && cap_high_s) begin
                    next_state_s = DS_ONE ? ST_SCAN : ST_RELEASE;
                end else begin
                    next_state_s = ST_HELD;
                end
            end
            ST_RELEASE: begin
                if (sample_s) begin
                    if (cap_high_s) begin
                        next_state_s = (cnt_inc_s == DS_C) ? ST_SCAN : ST_RELEASE;
                    end else begin
                        next_state_s = ST_HELD;
                    end
                end else begin
                    next_state_s = ST_RELEASE;
                end
            end
            default: next_state_s = ST_SCAN;
        endcase
    end

    // FSM output/datapath logic: next values of row index, capture,
    // counters and the key outputs. Outputs load on the edge entering HELD
    // and clear on the edge leaving RELEASE.
    always_comb begin
        row_idx_nxt_s   = row_idx_r;
        cap_col_nxt_s   = cap_col_r;
        match_cnt_nxt_s = match_cnt_r;
        row_out_nxt_s   = row_out_r;
        col_out_nxt_s   = col_out_r;
        key_code_nxt_s  = key_code_r;
        key_valid_nxt_s = 1'b0;
        case (state_r)
            ST_SCAN: begin
                if (sample_s) begin
                    if (new_single_s) begin
                        cap_col_nxt_s   = new_col_s;
                        match_cnt_nxt_s = ONE_C;
                        if (DS_ONE) begin
                            row_out_nxt_s   = row_onehot(row_idx_r);
                            col_out_nxt_s   = col_onehot(new_col_s);
                            key_code_nxt_s  = key_map(row_idx_r, new_col_s);
                            key_valid_nxt_s = 1'b1;
                            match_cnt_nxt_s = ZERO_C;
                        end else begin
                            key_valid_nxt_s = 1'b0;
                        end
                    end else begin
                        // No key or several columns at once: move on.
                        row_idx_nxt_s   = row_idx_r + 2'd1;
                        match_cnt_nxt_s = ZERO_C;
                    end
                end else begin
                    key_valid_nxt_s = 1'b0;
                end
            end
            ST_DEBOUNCE: begin
                if (sample_s) begin
                    if (exact_match_s) begin
                        if (cnt_inc_s == DS_C) begin
                            row_out_nxt_s   = row_onehot(row_idx_r);
                            col_out_nxt_s   = col_onehot(cap_col_r);
                            key_code_nxt_s  = key_map(row_idx_r, cap_col_r);
                            key_valid_nxt_s = 1'b1;
                            match_cnt_nxt_s = ZERO_C;
                        end else begin
                            match_cnt_nxt_s = cnt_inc_s;
                        end
                    end else begin
                        row_idx_nxt_s   = row_idx_r + 2'd1;
                        match_cnt_nxt_s = ZERO_C;
                    end
                end else begin
                    key_valid_nxt_s = 1'b0;
                end
            end
            ST_HELD: begin
                if (sample_s && cap_high_s) begin
                    if (DS_ONE) begin
                        row_out_nxt_s   = 4'b0000;
                        col_out_nxt_s   = 3'b000;
                        row_idx_nxt_s   = row_idx_r + 2'd1;
                        match_cnt_nxt_s = ZERO_C;
                    end else begin
                        match_cnt_nxt_s = ONE_C;
                    end
                end else begin
                    key_valid_nxt_s = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (sample_s) begin
                    if (cap_high_s) begin
                        if (cnt_inc_s == DS_C) begin
                            row_out_nxt_s   = 4'b0000;
                            col_out_nxt_s   = 3'b000;
                            row_idx_nxt_s   = row_idx_r + 2'd1;
                            match_cnt_nxt_s = ZERO_C;
                        end else begin
                            match_cnt_nxt_s = cnt_inc_s;
                        end
                    end else begin
                        // Bounce back to pressed: resume holding silently.
                        match_cnt_nxt_s = ZERO_C;
                    end
                end else begin
                    key_valid_nxt_s = 1'b0;
                end
            end
            default: begin
                row_idx_nxt_s   = 2'd0;
                match_cnt_nxt_s = ZERO_C;
                row_out_nxt_s   = 4'b0000;
                col_out_nxt_s   = 3'b000;
            end
        endcase
    end

    // Datapath and output registers; row drive is registered from the
    // next row index so it tracks r on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_idx_r   <= 2'd0;
            cap_col_r   <= 2'd0;
            match_cnt_r <= ZERO_C;
            row_drv_r   <= 4'b1110;
            row_out_r   <= 4'b0000;
            col_out_r   <= 3'b000;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
        end else begin
            row_idx_r   <= row_idx_nxt_s;
            cap_col_r   <= cap_col_nxt_s;
            match_cnt_r <= match_cnt_nxt_s;
            row_drv_r   <= ~row_onehot(row_idx_nxt_s);
            row_out_r   <= row_out_nxt_s;
            col_out_r   <= col_out_nxt_s;
            key_code_r  <= key_code_nxt_s;
            key_valid_r <= key_valid_nxt_s;
        end
    end

    assign kp_row_drv = row_drv_r;
    assign row1       = row_out_r[0];
    assign row2       = row_out_r[1];
    assign row3       = row_out_r[2];
    assign row4       = row_out_r[3];
    assign col1       = col_out_r[0];
    assign col2       = col_out_r[1];
    assign col3       = col_out_r[2];
    assign key_code   = key_code_r;
    assign key_valid  = key_valid_r;

endmodule
